// File: rtl/sub64_pkg.sv
// Shared width, state encoding and slice-count helper for the sequential 64-bit subtractor.
package sub64_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int nslice(input int slice_w);
        return DATA_W / slice_w;
    endfunction

endpackage

// File: rtl/sub64_seq_if.sv
// Operand/result handshake bundle between a producer/consumer and sub64_seq.
interface sub64_seq_if;
    import sub64_pkg::*;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] q;
    logic              borrow_out;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, q, borrow_out, out_valid
    );

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, q, borrow_out, out_valid
    );

endinterface

// File: rtl/sub_slice.sv
// One SLICE_W-bit subtract stage with borrow in/out.
// Latency: combinational.
// Backpressure: none.
module sub_slice #(
    parameter int SLICE_W = 16
) (
    input  logic [SLICE_W-1:0] a_s,
    input  logic [SLICE_W-1:0] b_s,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] diff,
    output logic               borrow
);

    assign {borrow, diff} = {1'b0, a_s} - {1'b0, b_s} - {{SLICE_W{1'b0}}, borrow_in};

endmodule

// File: rtl/sub64_seq.sv
// 64-bit a - b computed one SLICE_W slice per cycle through a single shared sub_slice.
// Latency: result valid 64/SLICE_W cycles after the accept edge.
// Backpressure: holds the result until out_ready; in_ready only while idle.
module sub64_seq
    import sub64_pkg::*;
#(
    parameter int SLICE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    sub64_seq_if.slave  io
);

    localparam int NSLICE = nslice(SLICE_W);
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              brw;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] q_r;
    logic              borrow_out_r;

    logic [SLICE_W-1:0] a_s;
    logic [SLICE_W-1:0] b_s;
    logic [SLICE_W-1:0] diff_s;
    logic               borrow_s;

    // Only the active slice feeds the subtractor, so the borrow chain stays SLICE_W bits long.
    assign a_s = a_r[int'(cnt) * SLICE_W +: SLICE_W];
    assign b_s = b_r[int'(cnt) * SLICE_W +: SLICE_W];

    sub_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a_s       (a_s),
        .b_s       (b_s),
        .borrow_in (brw),
        .diff      (diff_s),
        .borrow    (borrow_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.in_valid)  state_nxt = CALC;
            CALC:    if (cnt == LAST)  state_nxt = HOLD;
            HOLD:    if (io.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            brw          <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            q_r          <= '0;
            borrow_out_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        a_r <= io.a;
                        b_r <= io.b;
                        cnt <= '0;
                        brw <= 1'b0;
                    end
                end
                CALC: begin
                    q_r[int'(cnt) * SLICE_W +: SLICE_W] <= diff_s;
                    brw <= borrow_s;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        borrow_out_r <= borrow_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode state only; no path from in_valid or out_ready.
    assign io.in_ready   = (state == IDLE);
    assign io.out_valid  = (state == HOLD);
    assign io.q          = q_r;
    assign io.borrow_out = borrow_out_r;

endmodule
